// File: rtl/gate_lu_pkg.sv
// Shared opcode and output-register state definitions for the gate logic unit and its arbiter.
package gate_lu_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_BUF  = 3'd0,
        OP_NOT  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NAND = 3'd6,
        OP_NOR  = 3'd7
    } opcode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/gate_cells.sv
// Single-bit gate primitives used to build the shared logic unit.
module gate_buf (
    input  logic a,
    output logic y
);
    assign y = a;
endmodule

module gate_not (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module gate_and (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module gate_or (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module gate_xor (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module gate_xnor (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a ^ b);
endmodule

module gate_nand (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

module gate_nor (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a | b);
endmodule

// File: rtl/gate_lu.sv
// Combinational W-bit logic unit: every gate type is evaluated per bit and the opcode picks one.
module gate_lu
    import gate_lu_pkg::*;
#(
    parameter int W = 8
) (
    input  opcode_e        i_op,
    input  logic [W-1:0]   i_e1,
    input  logic [W-1:0]   i_e2,
    output logic [W-1:0]   o_s
);

    logic [W-1:0] w_buf;
    logic [W-1:0] w_not;
    logic [W-1:0] w_and;
    logic [W-1:0] w_or;
    logic [W-1:0] w_xor;
    logic [W-1:0] w_xnor;
    logic [W-1:0] w_nand;
    logic [W-1:0] w_nor;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            gate_buf  u_buf  (.a(i_e1[gi]),                  .y(w_buf[gi]));
            gate_not  u_not  (.a(i_e1[gi]),                  .y(w_not[gi]));
            gate_and  u_and  (.a(i_e1[gi]), .b(i_e2[gi]),    .y(w_and[gi]));
            gate_or   u_or   (.a(i_e1[gi]), .b(i_e2[gi]),    .y(w_or[gi]));
            gate_xor  u_xor  (.a(i_e1[gi]), .b(i_e2[gi]),    .y(w_xor[gi]));
            gate_xnor u_xnor (.a(i_e1[gi]), .b(i_e2[gi]),    .y(w_xnor[gi]));
            gate_nand u_nand (.a(i_e1[gi]), .b(i_e2[gi]),    .y(w_nand[gi]));
            gate_nor  u_nor  (.a(i_e1[gi]), .b(i_e2[gi]),    .y(w_nor[gi]));
        end
    endgenerate

    always_comb begin
        o_s = w_buf;
        case (i_op)
            OP_BUF:  o_s = w_buf;
            OP_NOT:  o_s = w_not;
            OP_AND:  o_s = w_and;
            OP_OR:   o_s = w_or;
            OP_XOR:  o_s = w_xor;
            OP_XNOR: o_s = w_xnor;
            OP_NAND: o_s = w_nand;
            OP_NOR:  o_s = w_nor;
            default: o_s = w_buf;
        endcase
    end

endmodule

// File: rtl/gate_lu_arbiter.sv
// Round-robin arbiter sharing one gate_lu among N requesters, with a one-entry output register.
// Define GATE_LU_ARB_STATS_EN to add per-requester saturating grant counters on grant_cnt.
module gate_lu_arbiter
    import gate_lu_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*OPW-1:0]     req_op,
    input  logic [N*W-1:0]       req_e1,
    input  logic [N*W-1:0]       req_e2,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [W-1:0]         resp_s,
    output logic [IDW-1:0]       resp_id
`ifdef GATE_LU_ARB_STATS_EN
    ,
    output logic [N*16-1:0]      grant_cnt
`endif
);

    out_state_e       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [W-1:0]     r_s;
    logic [IDW-1:0]   r_id;

    logic             w_any;
    logic [IDW-1:0]   w_win;
    logic             w_can_accept;
    logic             w_accept;
    logic [OPW-1:0]   w_op;
    logic [W-1:0]     w_e1;
    logic [W-1:0]     w_e2;
    logic [W-1:0]     w_s;
    logic [IDW-1:0]   w_ptr_next;

    // Scan N slots starting at the pointer; the nested compare keeps every index constant.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_any && req_valid[i] && (((int'(r_ptr) + k) % N) == i)) begin
                    w_any = 1'b1;
                    w_win = i[IDW-1:0];
                end
            end
        end
    end

    assign w_can_accept = (r_state == ST_EMPTY) || resp_ready;
    assign w_accept     = w_any && w_can_accept && !rst;
    assign w_ptr_next   = (int'(w_win) == N - 1) ? '0 : w_win + 1'b1;

    always_comb begin
        req_ready = '0;
        w_op      = '0;
        w_e1      = '0;
        w_e2      = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win == i[IDW-1:0]) begin
                req_ready[i] = w_accept;
                w_op         = req_op[i*OPW +: OPW];
                w_e1         = req_e1[i*W +: W];
                w_e2         = req_e2[i*W +: W];
            end
        end
    end

    gate_lu #(
        .W (W)
    ) u_lu (
        .i_op (opcode_e'(w_op)),
        .i_e1 (w_e1),
        .i_e2 (w_e2),
        .o_s  (w_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_ptr   <= '0;
            r_s     <= '0;
            r_id    <= '0;
        end else if (w_accept) begin
            r_state <= ST_FULL;
            r_ptr   <= w_ptr_next;
            r_s     <= w_s;
            r_id    <= w_win;
        end else if ((r_state == ST_FULL) && resp_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign resp_valid = (r_state == ST_FULL);
    assign resp_s     = r_s;
    assign resp_id    = r_id;

`ifdef GATE_LU_ARB_STATS_EN
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cnt
            logic [15:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (req_ready[gi] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign grant_cnt[gi*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule

// File: doc/gate_lu_arbiter.md
Name: gate_lu_arbiter

Overview:
- Shares one W-bit logic unit among N requesters.
- The logic unit is built from the library's two-input and single-input gate primitives (buf, not, and, or, xor, xnor, nand, nor).
- Round-robin arbitration picks one request per cycle; the result is registered and returned with the winner's ID.
- Sits between independent control FSMs and a single logic-op resource, replacing N private gate arrays.

Parameters:
- N, 4, number of requesters (2..8).
- W, 8, operand/result width in bits.
- IDW, 2, requester ID width; must equal max(1, clog2(N)).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  per-requester accept; one-hot or zero.
- req_op  in  N*3  per-requester opcode, requester i at bits [3i+2:3i].
- req_e1  in  N*W  per-requester operand 1.
- req_e2  in  N*W  per-requester operand 2; ignored for BUF/NOT.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_s  out  W  result.
- resp_id  out  IDW  index of the requester that produced the result.

Behaviour:
- Opcodes (3 bits): 0 BUF s=e1; 1 NOT s=~e1; 2 AND; 3 OR; 4 XOR; 5 XNOR; 6 NAND; 7 NOR. All are bitwise over W bits.
- Output register states:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
  - can_accept = EMPTY | (FULL & resp_ready).
- Arbitration:
  - Round-robin pointer ptr (IDW bits). Search order is ptr, ptr+1, ..., wrapping modulo N.
  - The first requester with req_valid=1 wins.
  - req_ready[win]=1 only when can_accept; every other req_ready bit is 0.
  - req_ready is combinational from req_valid, ptr and state; it never depends on req_ready itself.
- On accept (req_valid[win] & req_ready[win]):
  - Next edge: resp_s = op(e1,e2) of the winner, resp_id = win, resp_valid=1.
  - ptr = win+1 mod N.
  - Latency: accept at edge k gives resp_valid from edge k+1.
- Draining:
  - resp_valid & resp_ready with no new accept → EMPTY next edge.
  - Drain and accept in the same cycle → stays FULL with the new data. Full throughput is one op per cycle.
- While FULL & !resp_ready:
  - resp_s and resp_id are held stable.
  - All req_ready bits are 0.
  - ptr is unchanged.
- Requests:
  - A requester may drop req_valid before it is accepted (no stickiness required).
  - Payload is sampled only on the accept cycle.
- Boundary cases:
  - N not a power of two: ptr wraps from N-1 to 0. Indices ≥ N are never granted.
  - All req_valid=0: no grant, ptr unchanged.
- Reset (synchronous, any cycle, including while FULL):
  - resp_valid=0, resp_s=0, resp_id=0, ptr=0.
  - req_ready=0 during the reset cycle.
  - An in-flight result is discarded.
- Reset values of all outputs: resp_valid=0, resp_s=0, resp_id=0, req_ready=0.

Optional Feature:
- Macro GATE_LU_ARB_STATS_EN. When defined:
  - Adds output port grant_cnt (N*16 bits): per-requester saturating accept counters.
  - Each counter increments on that requester's accept, holds at 16'hFFFF, and clears on rst.
- When undefined: the port and counters are absent, with no other behavioural difference.

Decomposition:
- Package gate_lu_pkg holds:
  - the 3-bit opcode typedef and its eight named constants;
  - the opcode width constant OPW=3.
- Sub-module gate_lu (combinational, W-parameterised):
  - instantiates per-bit gate_buf, gate_not, gate_and, gate_or, gate_xor, gate_xnor, gate_nand and gate_nor;
  - an opcode mux selects the result.
- The arbiter, output register and optional counters live in gate_lu_arbiter.

Test Plan:
- Reset then idle: after rst, resp_valid=0, resp_s=0, req_ready=0. With no requests for 5 cycles, nothing changes.
- Single request: requester 2, op AND, e1=8'hF0, e2=8'h3C, resp_ready=1 → next cycle resp_valid=1, resp_s=8'h30, resp_id=2.
- Fairness: all four requesters hold valid, resp_ready=1 → grants 0,1,2,3,0,... one per cycle. Opcodes NOT/XOR/NAND/NOR on e1=8'hAA, e2=8'h0F give 8'h55/8'hA5/8'hF5/8'h50.
- Backpressure: resp_ready=0 for 3 cycles while FULL → resp_s/resp_id stable and req_ready=0. On release with simultaneous drain and accept → the new result appears the next cycle with no bubble.
- Reset mid-operation: assert rst while FULL with resp_ready=0 → next cycle resp_valid=0 and ptr=0; first post-reset grant goes to requester 0 when all are valid.
- N=3 configuration: all valid → grant order 0,1,2,0. With GATE_LU_ARB_STATS_EN defined, after 300 grants to requester 1, grant_cnt for requester 1 = 300.
